// File: rtl/taillight_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : taillight_fsm
//  Purpose  : Upstream control for the taillight output logic. Synchronizes
//             and debounces the switch inputs, divides clk into a slow blink
//             tick, and runs the frame-aligned mode state machine whose
//             CurrentState drives the output-logic stage directly.
//  Revision : 1.0 - initial release
// ============================================================================
module taillight_fsm #(
  parameter int TICK_DIV        = 12500000,  // clk cycles per blink tick (>=2)
  parameter int DEBOUNCE_CYCLES = 500000     // stable cycles to accept a change (>=1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] SW,            // [1]=hazard request, [0]=turn request
  input  logic       turn_side,     // 0=left, 1=right
  output logic [2:0] CurrentState,
  output logic       tick,
  output logic       frame_start
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int c_DIV_W = $clog2(TICK_DIV);
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Last divider count (tick cycle) and the count just before it; the tick
  // and frame_start flops are loaded one cycle early so they are true
  // registers yet line up exactly with the count of TICK_DIV-1.
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_PRE  = c_DIV_W'(TICK_DIV - 2);
  localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  // Input vector bit positions: {hazard, turn, side}
  localparam int c_BIT_HAZ  = 2;
  localparam int c_BIT_TURN = 1;
  localparam int c_BIT_SIDE = 0;

  // Mode encoding seen by the output-logic stage; 1xx is never produced.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'b000,
    ST_HAZARDS    = 3'b001,
    ST_TURN_LEFT  = 3'b010,
    ST_TURN_RIGHT = 3'b011
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [2:0]         r_cand;
  logic [2:0]         r_deb;
  logic [c_CNT_W-1:0] r_cnt;

  logic [c_DIV_W-1:0] r_div;
  logic               r_tick;
  logic               r_frame_start;
  logic [1:0]         r_fc;
  state_t             r_state;

  state_t             w_req;
  logic               w_fc_last;
  logic               w_tick_next;

  // Two-flop synchronizer for the asynchronous switch and side inputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {SW, turn_side};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: a new synchronized value must stay put long enough before it
  // replaces the accepted vector; any wobble restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cand <= 3'b000;
      r_deb  <= 3'b000;
      r_cnt  <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cand != r_deb) begin
      if (r_cnt == c_DEB_LAST) begin
        r_deb <= r_cand;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // The next cycle is a tick cycle when the divider is one short of its end
  assign w_tick_next = (r_div == c_DIV_PRE);

  // Free-running blink divider with a registered one-cycle tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_div == c_DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_tick <= w_tick_next;
    end
  end

  // Requested mode from the debounced inputs; hazard outranks turn
  always_comb begin
    w_req = ST_IDLE;
    if (r_deb[c_BIT_HAZ]) begin
      w_req = ST_HAZARDS;
    end else if (r_deb[c_BIT_TURN]) begin
      w_req = r_deb[c_BIT_SIDE] ? ST_TURN_RIGHT : ST_TURN_LEFT;
    end
  end

  // Slot 3 is the frame-completing tick where ordinary mode changes land
  assign w_fc_last = (r_fc == 2'd3);

  // Mode FSM plus frame counter; both advance only on tick cycles.
  // frame_start is preloaded in the cycle before a tick, when fc is stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_fc          <= 2'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick_next && (r_fc == 2'd0);
      if (r_tick) begin
        r_fc <= r_fc + 2'd1;
        case (r_state)
          ST_IDLE: begin
            // Leaving idle restarts the frame: this tick becomes slot 0
            if (w_req != ST_IDLE) begin
              r_state <= w_req;
              r_fc    <= 2'd1;
            end
          end
          ST_TURN_LEFT, ST_TURN_RIGHT: begin
            // Hazard cuts in at once; anything else waits for frame end
            if (w_req == ST_HAZARDS) begin
              r_state <= ST_HAZARDS;
            end else if ((w_req != r_state) && w_fc_last) begin
              r_state <= w_req;
            end
          end
          ST_HAZARDS: begin
            if ((w_req != ST_HAZARDS) && w_fc_last) begin
              r_state <= w_req;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign CurrentState = r_state;
  assign tick         = r_tick;
  assign frame_start  = r_frame_start;

endmodule
`default_nettype wire
